// File: rtl/prog_mem_loader.sv
// prog_mem_loader
//
// Program/data RAM of 2^AW words x DW bits that sits directly on the CPU
// memory bus. A byte-stream loader port fills the RAM and then delivers a
// trailing checksum. The CPU is held in reset until a complete image has
// arrived and its checksum matches. A new image can be loaded at any time
// by pulsing ld_start.
//
// Ports
//   clk              system clock, rising edge
//   reset_n          asynchronous active-low reset
//   ld_start         one-cycle pulse that begins or restarts a load
//   ld_valid         ld_data carries a byte
//   ld_data          2^AW program words, then one checksum byte
//   ld_ready         loader accepts a byte this cycle
//   cpu_reset_n      registered active-low reset to the CPU
//   cpu_mem_address  CPU read/write address
//   cpu_mem_data_w   CPU write data
//   cpu_mem_we       CPU write enable (honoured only while running)
//   cpu_mem_data_r   combinational read data at cpu_mem_address
//   load_done        last load passed its checksum; CPU running
//   load_error       last load failed its checksum
//   load_count       words accepted in the current load
module prog_mem_loader #(
  parameter int AW       = 4,
  parameter int DW       = 8,
  parameter int BOOT_RUN = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  output logic          cpu_reset_n,
  input  logic [AW-1:0] cpu_mem_address,
  input  logic [DW-1:0] cpu_mem_data_w,
  input  logic          cpu_mem_we,
  output logic [DW-1:0] cpu_mem_data_r,
  output logic          load_done,
  output logic          load_error,
  output logic [AW:0]   load_count
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CHECK = 3'd2,
    ST_RUN   = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  localparam int   DEPTH       = 1 << AW;
  localparam state_t RESET_STATE = (BOOT_RUN != 0) ? ST_RUN : ST_IDLE;
  localparam logic RESET_CPU_N = (BOOT_RUN != 0);
  // Index of the final program word; accepting it moves on to the checksum.
  localparam logic [AW:0] LAST_WORD = {1'b0, {AW{1'b1}}};

  state_t        state_q, state_d;
  logic [AW:0]   counter_q, counter_d;
  logic [DW-1:0] acc_q, acc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          cpu_rst_n_q, cpu_rst_n_d;

  logic          handshake;
  logic          ld_wr_en;
  logic          cpu_wr_en;
  logic          sum_match;

  logic [DW-1:0] mem [0:DEPTH-1];

  assign handshake = ld_valid && ld_ready;
  assign sum_match = (ld_data == acc_q);

  // ------------------------------------------------------------------
  // FSM: state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_STATE;
    end else begin
      state_q <= state_d;
    end
  end

  // ------------------------------------------------------------------
  // FSM: next-state logic. ld_start wins over everything, including a
  // handshake presented in the same cycle.
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (ld_start) begin
      state_d = ST_LOAD;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (handshake && (counter_q == LAST_WORD)) begin
            state_d = ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (handshake) begin
            state_d = sum_match ? ST_RUN : ST_ERR;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // FSM: outputs decoded from the registered state.
  // ------------------------------------------------------------------
  always_comb begin
    ld_ready  = ((state_q == ST_LOAD) || (state_q == ST_CHECK)) && !ld_start;
    ld_wr_en  = (state_q == ST_LOAD) && handshake;
    cpu_wr_en = (state_q == ST_RUN) && cpu_mem_we;
  end

  // ------------------------------------------------------------------
  // Datapath: word counter, running checksum, status flags, CPU reset.
  // ------------------------------------------------------------------
  always_comb begin
    counter_d   = counter_q;
    acc_d       = acc_q;
    done_d      = done_q;
    err_d       = err_q;
    cpu_rst_n_d = cpu_rst_n_q;
    if (ld_start) begin
      counter_d   = '0;
      acc_d       = '0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      cpu_rst_n_d = 1'b0;
    end else if (ld_wr_en) begin
      counter_d = counter_q + 1'b1;
      acc_d     = acc_q + ld_data;
    end else if ((state_q == ST_CHECK) && handshake) begin
      if (sum_match) begin
        done_d      = 1'b1;
        cpu_rst_n_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q   <= '0;
      acc_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cpu_rst_n_q <= RESET_CPU_N;
    end else begin
      counter_q   <= counter_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

  // ------------------------------------------------------------------
  // Memory. Deliberately not reset so a partial image survives a reset.
  // The loader and CPU write ports are mutually exclusive by state, so a
  // single write port is enough. The read is asynchronous because the CPU
  // captures read data on the edge after it presents the address.
  // ------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (ld_wr_en) begin
      mem[counter_q[AW-1:0]] <= ld_data;
    end else if (cpu_wr_en) begin
      mem[cpu_mem_address] <= cpu_mem_data_w;
    end
  end

  assign cpu_mem_data_r = mem[cpu_mem_address];

  assign cpu_reset_n = cpu_rst_n_q;
  assign load_done   = done_q;
  assign load_error  = err_q;
  assign load_count  = counter_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
module tb_prog_mem_loader;

  logic       clk;
  logic       reset_n;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       cpu_reset_n;
  logic [3:0] cpu_mem_address;
  logic [7:0] cpu_mem_data_w;
  logic       cpu_mem_we;
  logic [7:0] cpu_mem_data_r;
  logic       load_done;
  logic       load_error;
  logic [4:0] load_count;

  prog_mem_loader #(.AW(4), .DW(8), .BOOT_RUN(0)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .ld_start        (ld_start),
    .ld_valid        (ld_valid),
    .ld_data         (ld_data),
    .ld_ready        (ld_ready),
    .cpu_reset_n     (cpu_reset_n),
    .cpu_mem_address (cpu_mem_address),
    .cpu_mem_data_w  (cpu_mem_data_w),
    .cpu_mem_we      (cpu_mem_we),
    .cpu_mem_data_r  (cpu_mem_data_r),
    .load_done       (load_done),
    .load_error      (load_error),
    .load_count      (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: phase of the loader, the list of words accepted in the
  // current load, and the memory image as the CPU should see it.
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;   // collecting words, then the checksum
  localparam int P_RUN  = 2;
  localparam int P_ERR  = 3;

  int         m_phase;
  logic [7:0] m_words [$];
  logic [7:0] m_mem   [16];
  bit         m_known [16];
  bit         m_done;
  bit         m_err;
  bit         m_cpu_n;
  bit         last_hs;
  int         txn = 0;

  function automatic logic [7:0] sum_words();
    logic [7:0] s = 8'h00;
    foreach (m_words[i]) s = s + m_words[i];
    return s;
  endfunction

  function automatic logic [4:0] exp_count();
    return (m_phase == P_IDLE) ? 5'd0 : 5'(m_words.size());
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE;
    m_words.delete();
    m_done  = 1'b0;
    m_err   = 1'b0;
    m_cpu_n = 1'b0;
  endtask

  // One clock cycle: drive inputs, check combinational outputs mid-cycle,
  // advance the model across the edge and check registered outputs.
  task automatic cycle(input logic st, input logic v, input logic [7:0] d,
                       input logic we, input logic [3:0] a, input logic [7:0] wd);
    bit exp_ready;
    ld_start        = st;
    ld_valid        = v;
    ld_data         = d;
    cpu_mem_we      = we;
    cpu_mem_address = a;
    cpu_mem_data_w  = wd;
    #4;
    exp_ready = (m_phase == P_LOAD) && !st;
    check_eq("ld_ready", ld_ready, exp_ready);
    if (m_known[a]) check_eq("cpu_rd", cpu_mem_data_r, m_mem[a]);
    last_hs = v && exp_ready;
    if (m_phase == P_RUN && we) begin
      m_mem[a]   = wd;
      m_known[a] = 1'b1;
    end
    if (st) begin
      m_phase = P_LOAD;
      m_words.delete();
      m_done  = 1'b0;
      m_err   = 1'b0;
      m_cpu_n = 1'b0;
    end else if (last_hs) begin
      if (m_words.size() < 16) begin
        m_mem[m_words.size()]   = d;
        m_known[m_words.size()] = 1'b1;
        m_words.push_back(d);
      end else if (d == sum_words()) begin
        m_phase = P_RUN;
        m_done  = 1'b1;
        m_cpu_n = 1'b1;
      end else begin
        m_phase = P_ERR;
        m_err   = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check_eq("cpu_reset_n", cpu_reset_n, m_cpu_n);
    check_eq("load_done", load_done, m_done);
    check_eq("load_error", load_error, m_err);
    check_eq("load_count", load_count, exp_count());
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 8'($urandom), 1'b0, 4'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_eq("rst_cpu_reset_n", cpu_reset_n, 1'b0);
    check_eq("rst_ld_ready", ld_ready, 1'b0);
    check_eq("rst_load_done", load_done, 1'b0);
    check_eq("rst_load_error", load_error, 1'b0);
    check_eq("rst_load_count", load_count, 5'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // gap_mode 0: back-to-back, 1: valid on odd cycles, 2: random valid.
  // Sends up to nbytes bytes of b after an ld_start; returns cycles used.
  task automatic send_load(input logic [7:0] b [17], input int nbytes,
                           input int gap_mode, output int ncyc);
    int idx = 0;
    bit v;
    cycle(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 4'($urandom), 8'($urandom));
    ncyc = 0;
    while (idx < nbytes && ncyc < 300) begin
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = ncyc[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      cycle(1'b0, v, b[idx], 1'($urandom), 4'($urandom), 8'($urandom));
      ncyc++;
      if (last_hs) idx++;
    end
    check_eq("load_progress", idx, nbytes);
    txn++;
    $display("txn %0d: load of %0d bytes mode %0d in %0d cycles, done=%0b err=%0b",
             txn, nbytes, gap_mode, ncyc, load_done, load_error);
  endtask

  logic [7:0] img [17];
  int         ncyc;

  initial begin
    reset_n = 1'b0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
    cpu_mem_we = 1'b0; cpu_mem_address = 4'h0; cpu_mem_data_w = 8'h00;
    foreach (m_known[i]) m_known[i] = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    idle_cycle();

    // Counting image with correct checksum, back-to-back.
    for (int i = 0; i < 16; i++) img[i] = 8'(i);
    img[16] = 8'h78;
    send_load(img, 17, 0, ncyc);
    check_eq("b2b_cycles", ncyc, 17);
    check_eq("b2b_done", load_done, 1'b1);
    check_eq("b2b_cpu_n", cpu_reset_n, 1'b1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'h5, 8'h00);
    check_eq("rd_addr5", cpu_mem_data_r, 8'h05);

    // Bad checksum.
    img[16] = 8'h00;
    send_load(img, 17, 0, ncyc);
    check_eq("bad_err", load_error, 1'b1);
    check_eq("bad_cpu_n", cpu_reset_n, 1'b0);
    idle_cycle();
    img[16] = 8'h78;
    send_load(img, 17, 0, ncyc);
    check_eq("recover_done", load_done, 1'b1);

    // Every other cycle idle.
    send_load(img, 17, 1, ncyc);
    check_eq("gap_cycles", ncyc, 34);
    check_eq("gap_done", load_done, 1'b1);

    // CPU write in RUN, then in ERR.
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 4'hE, 8'h0A);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h00);
    check_eq("run_write", cpu_mem_data_r, 8'h0A);
    img[16] = 8'h01;
    send_load(img, 17, 0, ncyc);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 4'hE, 8'h55);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 4'hE, 8'h00);
    check_eq("err_write_ignored", cpu_mem_data_r, 8'h0E);

    // Restart after 7 bytes, then a fresh full load.
    img[16] = 8'h78;
    send_load(img, 7, 0, ncyc);
    cycle(1'b1, 1'b1, 8'hAA, 1'b0, 4'h0, 8'h00);
    check_eq("restart_count", load_count, 5'd0);
    check_eq("restart_cpu_n", cpu_reset_n, 1'b0);
    send_load(img, 17, 0, ncyc);
    check_eq("restart_done", load_done, 1'b1);

    // Reset after 7 bytes.
    send_load(img, 7, 0, ncyc);
    do_reset();
    idle_cycle();
    check_eq("mid_rst_ready", ld_ready, 1'b0);

    // Random images, random gaps, random checksum validity.
    for (int r = 0; r < 8; r++) begin
      logic [7:0] s = 8'h00;
      for (int i = 0; i < 16; i++) begin
        img[i] = 8'($urandom);
        s = s + img[i];
      end
      img[16] = ($urandom_range(0, 2) != 0) ? s : s ^ 8'(1 << $urandom_range(0, 7));
      send_load(img, 17, 2, ncyc);
      for (int k = 0; k < 12; k++) begin
        cycle(1'b0, 1'($urandom), 8'($urandom), 1'($urandom),
              4'($urandom), 8'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
